// File: rtl/pwm_ramp.sv
// Amplitude ramp controller feeding a pwm instance: latches a target, period and
// step rate on req/ack, then walks ampl one LSB per (rate+1) PWM periods.
module pwm_ramp #(
    parameter int XLEN = 3,
    parameter int RW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic [XLEN-1:0] target,
    input  logic [XLEN:0]   period,
    input  logic [RW-1:0]   rate,
    input  logic            stop,
    output logic            ack,
    output logic            busy,
    output logic            done,
    output logic            sync,
    output logic [XLEN-1:0] ampl,
    output logic [XLEN:0]   duty
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] ampl_q;
    logic [XLEN-1:0] tgt_q;
    logic [XLEN:0]   duty_q;
    logic [XLEN:0]   pcnt_q;
    logic [RW-1:0]   hold_q;
    logic [RW-1:0]   rt_q;
    logic            ack_q;
    logic            done_q;
    logic            sync_q;

    logic [XLEN:0]   last_cnt;
    logic            boundary;
    logic            step;
    logic [XLEN:0]   pcnt_d;
    logic [XLEN-1:0] ampl_d;

    // Periods of 0 and 1 both collapse to a boundary on every cycle.
    always_comb begin
        last_cnt = (duty_q[XLEN:1] == '0) ? '0 : duty_q - 1'b1;
        boundary = (pcnt_q == last_cnt);
        step     = boundary && (hold_q == rt_q);
        pcnt_d   = boundary ? '0 : pcnt_q + 1'b1;
        ampl_d   = (ampl_q < tgt_q) ? ampl_q + 1'b1 : ampl_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ampl_q  <= '0;
            tgt_q   <= '0;
            duty_q  <= '0;
            pcnt_q  <= '0;
            hold_q  <= '0;
            rt_q    <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            done_q <= 1'b0;
            sync_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        tgt_q  <= target;
                        rt_q   <= rate;
                        duty_q <= period;
                        pcnt_q <= '0;
                        hold_q <= '0;
                        ack_q  <= 1'b1;
                        if (target == ampl_q) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    // An abort wins over any step landing on the same edge.
                    if (stop) begin
                        state_q <= IDLE;
                    end else begin
                        pcnt_q <= pcnt_d;
                        sync_q <= boundary;
                        if (step) begin
                            hold_q <= '0;
                            ampl_q <= ampl_d;
                            if (ampl_d == tgt_q) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end
                        end else if (boundary) begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack  = ack_q;
    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sync = sync_q;
    assign ampl = ampl_q;
    assign duty = duty_q;

endmodule

// File: tb/tb_pwm_ramp.sv
// Directed bench for pwm_ramp: each accepted request pushes its predicted
// per-cycle outputs (derived from the step timing formula) into a scoreboard.
module tb_pwm_ramp;

    localparam int XLEN = 3;
    localparam int RW   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req = 1'b0;
    logic            stop = 1'b0;
    logic [XLEN-1:0] target = '0;
    logic [XLEN:0]   period = '0;
    logic [RW-1:0]   rate = '0;
    logic            ack, busy, done, sync;
    logic [XLEN-1:0] ampl;
    logic [XLEN:0]   duty;

    always #5 clk = ~clk;

    pwm_ramp #(.XLEN(XLEN), .RW(RW)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .target (target),
        .period (period),
        .rate   (rate),
        .stop   (stop),
        .ack    (ack),
        .busy   (busy),
        .done   (done),
        .sync   (sync),
        .ampl   (ampl),
        .duty   (duty)
    );

    typedef struct packed {
        logic [XLEN-1:0] ampl;
        logic [XLEN:0]   duty;
        logic            busy;
        logic            ack;
        logic            done;
        logic            sync;
    } obs_t;

    typedef struct {
        obs_t v;
        bit   chk_sync;
    } exp_t;

    exp_t            sb[$];
    int              tests = 0;
    int              fails = 0;
    logic [XLEN-1:0] cur_ampl = '0;

    function automatic obs_t observe();
        obs_t o;
        o.ampl = ampl;
        o.duty = duty;
        o.busy = busy;
        o.ack  = ack;
        o.done = done;
        o.sync = sync;
        return o;
    endfunction

    task automatic check(input string tag, input obs_t obs, input obs_t expv, input bit chk_sync);
        obs_t a;
        obs_t e;
        a = obs;
        e = expv;
        if (!chk_sync) begin
            a.sync = 1'b0;
            e.sync = 1'b0;
        end
        tests++;
        assert (a === e) else begin
            fails++;
            $error("FAIL %s: observed ampl=%0d duty=%0d busy=%b ack=%b done=%b sync=%b, expected ampl=%0d duty=%0d busy=%b ack=%b done=%b sync=%b",
                   tag, obs.ampl, obs.duty, obs.busy, obs.ack, obs.done, obs.sync,
                   expv.ampl, expv.duty, expv.busy, expv.ack, expv.done, expv.sync);
        end
    endtask

    // Sample s is taken after the s-th edge following the accept edge.
    function automatic void push_ramp(input logic [XLEN-1:0] tgt, input logic [XLEN:0] per,
                                      input logic [RW-1:0] rt, input int stop_s, input int tail,
                                      output int n_samples);
        int p;
        int l;
        int a0;
        int t;
        int n;
        int dir;
        int last;
        int fin;
        int k;
        exp_t e;
        p    = (per < 2) ? 1 : int'(per);
        l    = p * (int'(rt) + 1);
        a0   = int'(cur_ampl);
        t    = int'(tgt);
        n    = (t > a0) ? t - a0 : a0 - t;
        dir  = (t > a0) ? 1 : -1;
        last = n * l;
        fin  = (stop_s >= 0) ? stop_s : last;
        for (int s = 0; s <= fin + tail; s++) begin
            e.chk_sync = 1'b1;
            e.v.duty   = per;
            if (stop_s >= 0 && s >= stop_s) begin
                k = (stop_s - 1) / l;
                if (k > n) k = n;
                e.v.ampl = XLEN'(a0 + dir * k);
                e.v.busy = 1'b0;
                e.v.ack  = 1'b0;
                e.v.done = 1'b0;
                e.v.sync = 1'b0;
                if (s == stop_s) e.chk_sync = 1'b0;
            end else begin
                k = s / l;
                if (k > n) k = n;
                e.v.ampl = XLEN'(a0 + dir * k);
                e.v.busy = (s < last);
                e.v.ack  = (s == 0);
                e.v.done = (s == last);
                e.v.sync = (s >= 1) && (s <= last) && (s % p == 0);
            end
            sb.push_back(e);
        end
        if (stop_s >= 0) begin
            k = (stop_s - 1) / l;
            if (k > n) k = n;
            cur_ampl = XLEN'(a0 + dir * k);
        end else begin
            cur_ampl = tgt;
        end
        n_samples = fin + tail + 1;
    endfunction

    task automatic ramp(input string tag, input logic [XLEN-1:0] tgt, input logic [XLEN:0] per,
                        input logic [RW-1:0] rt, input int stop_s, input int spur_s);
        int   n;
        exp_t e;
        @(negedge clk);
        req    = 1'b1;
        target = tgt;
        period = per;
        rate   = rt;
        @(posedge clk);
        push_ramp(tgt, per, rt, stop_s, 2, n);
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            req = 1'b0;
            e = sb.pop_front();
            check($sformatf("%s s=%0d", tag, s), observe(), e.v, e.chk_sync);
            if (s + 1 == spur_s) begin
                req    = 1'b1;
                target = '0;
                period = 4'd5;
                rate   = '0;
            end
            stop = (s + 1 == stop_s);
        end
        req  = 1'b0;
        stop = 1'b0;
    endtask

    initial begin
        obs_t z;
        z = '0;

        #3 rst = 1'b0;
        #1 check("reset", observe(), z, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        ramp("up 0->4 p7 r0",   3'd4, 4'd7, 4'd0, -1, -1);
        ramp("down 4->1 p3 r1", 3'd1, 4'd3, 4'd1, -1, -1);
        ramp("prep 1->5",       3'd5, 4'd1, 4'd0, -1, -1);
        ramp("equal 5",         3'd5, 4'd6, 4'd0, -1, -1);
        ramp("prep 5->0",       3'd0, 4'd1, 4'd0, -1, -1);
        ramp("busy req 0->7",   3'd7, 4'd2, 4'd0, -1,  4);
        ramp("stop at 3",       3'd0, 4'd1, 4'd0,  5, -1);
        ramp("p0 r2 3->5",      3'd5, 4'd0, 4'd2, -1, -1);
        ramp("p1 r2 5->3",      3'd3, 4'd1, 4'd2, -1, -1);

        // Asynchronous reset in the middle of a running ramp.
        @(negedge clk);
        req    = 1'b1;
        target = 3'd7;
        period = 4'd2;
        rate   = '0;
        @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("async reset mid-cycle", observe(), z, 1'b1);
        @(negedge clk);
        check("reset held", observe(), z, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("after reset c=%0d", i), observe(), z, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_ramp.md
# pwm_ramp

Amplitude ramp controller for the `pwm` block. It accepts a target amplitude, a PWM period and a step rate over a req/ack handshake. It then drives the PWM `ampl` and `duty` inputs, stepping `ampl` by one LSB toward the target at PWM period boundaries, so amplitude never changes mid-period. It sits between a control/register agent and one `pwm` instance.

## Interface
Parameters:
- `XLEN`, default 3: amplitude width. The period/duty width is XLEN+1.
- `RW`, default 4: width of the rate field.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  1  ramp request, sampled on `clk`.
- `target`  in  XLEN  final amplitude, latched on accept.
- `period`  in  XLEN+1  PWM period in cycles, latched on accept.
- `rate`  in  RW  extra periods per step. A step occurs every rate+1 periods.
- `stop`  in  1  abort the running ramp.
- `ack`  out  1  one-cycle pulse: request accepted.
- `busy`  out  1  high while a ramp is running.
- `done`  out  1  one-cycle pulse: `ampl` reached `target`.
- `sync`  out  1  one-cycle pulse after each period boundary while busy.
- `ampl`  out  XLEN  to `pwm` `ampl`.
- `duty`  out  XLEN+1  to `pwm` `duty` (period).

## Operation
- States: IDLE and RUN. `busy` = (state == RUN).
- Internal registers:
  - `pcnt` (XLEN+1): period counter.
  - `hold` (RW): periods counted since the last step.
  - latched `tgt` and `rt`.
- Effective period P = max(`duty`, 1). Values 0 and 1 both mean a boundary on every cycle.
- IDLE with `req`=1 at an edge (accept):
  - latch `tgt`=`target`, `rt`=`rate`, `duty`=`period`; clear `pcnt` and `hold`; pulse `ack`.
  - If `target` == current `ampl`: stay IDLE and pulse `done` together with `ack`. `busy` stays 0.
  - Otherwise go to RUN.
- `req` while RUN is ignored: no `ack`, and latched values are unchanged.
- RUN, every edge: `pcnt` increments. A boundary edge is one where `pcnt` == P-1; `pcnt` wraps to 0.
- At a boundary edge, `sync` pulses next cycle, and:
  - if `hold` == `rt`: `hold`←0 and `ampl` steps ±1 toward `tgt`;
  - else `hold`←`hold`+1.
- If the step makes `ampl` == `tgt`: go to IDLE and pulse `done`.
- Direction is decided by an unsigned compare of `ampl` and `tgt`. `ampl` never overshoots and never wraps.
- `stop` in RUN: go to IDLE at that edge. `ampl` and `duty` hold their current values; no `done`.
  - `stop` takes priority over a step on the same edge.
  - `stop` in IDLE has no effect. If `req` and `stop` are both high in IDLE, the request is accepted.
- `duty` and `ampl` keep their last values in IDLE, so the PWM keeps running at the final level.

## Timing
- Reset (`rst`=0, asynchronous, no clock needed): state IDLE, `ampl`=0, `duty`=0, `pcnt`=0, `hold`=0, and `ack`/`done`/`busy`/`sync`=0.
- `ack`, `done`, `sync` and `busy` are registered outputs, each valid in the cycle after its causing edge.
- Accept at edge E0:
  - `ack`=1 and `busy`=1 in cycle E0+1, and `duty` is updated at E0.
  - The k-th step lands at edge E0 + k·P·(rt+1).
- For N = |target − ampl|: the last step is at E0 + N·P·(rt+1). `done`=1 and `busy`=0 in the following cycle.
- A new `req` is accepted at the earliest on the edge after `busy` falls, i.e. in the cycle where `done` is high.
- `rst` asserted mid-ramp aborts immediately; no `done`.

## Test plan
- Reset: assert `rst`=0 mid-cycle → `ampl`=0, `duty`=0, `busy`=`ack`=`done`=`sync`=0 before the next edge.
- Ramp up with XLEN=3, `period`=7, `rate`=0, `target`=4 from `ampl`=0:
  - `ack` in cycle E0+1;
  - `ampl` becomes 1, 2, 3, 4 at E0+7, 14, 21, 28;
  - `done` pulses and `busy` falls in cycle E0+29;
  - `sync` pulses every 7 cycles.
- Ramp down 4→1 with `period`=3, `rate`=1: `ampl` becomes 3, 2, 1 at E0+6, 12, 18; `done` once.
- `target` == `ampl` (both 5): `ack` and `done` pulse in the same cycle, `busy` stays 0, `ampl` is unchanged.
- `req` with `target`=0 during a 0→7 ramp: no `ack`, and the ramp still ends at 7.
- `stop` at the edge after `ampl` reaches 3: `ampl` frozen at 3, `busy`=0, no `done`.
- `period`=0 and `period`=1 with `rate`=2: `ampl` steps every 3 cycles.
- Async reset mid-ramp: outputs go to their reset values, and no `done` pulse follows.
